// File: rtl/ds_decimator.sv
// Second-order CIC decimator for a 1-bit delta-sigma bitstream, R = 2**C_DEC_LOG2.
// Define DS_DECIMATOR_SATURATE_EN to clamp full scale instead of truncating it.
module ds_decimator #(
    parameter int unsigned C_DEC_LOG2 = 6,
    parameter int unsigned C_OUT_BITS = 16
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  DS_IN,
    input  logic                  DS_EN,
    input  logic                  SYNC_CLR,
    output logic [C_OUT_BITS-1:0] DATA,
    output logic                  VALID
);

    localparam int unsigned W     = 2 * C_DEC_LOG2 + 1;
    localparam int unsigned MW    = 2 * C_DEC_LOG2;
    localparam int unsigned SHIFT = C_OUT_BITS - MW;

    typedef enum logic [1:0] {
        StWarm0,
        StWarm1,
        StRun
    } state_e;

    state_e                  state_q;
    logic [W-1:0]            i1_q;
    logic [W-1:0]            i2_q;
    logic [W-1:0]            i2_dly_q;
    logic [W-1:0]            c1_dly_q;
    logic [C_DEC_LOG2-1:0]   cnt_q;
    logic                    tick_q;
    logic [MW-1:0]           map_q;
    logic                    upd_q;
    logic                    pend_q;
    logic [C_OUT_BITS-1:0]   data_q;
    logic                    valid_q;

    logic [W-1:0]            i1_nxt;
    logic [W-1:0]            i2_nxt;
    logic [W-1:0]            c1;
    logic [MW-1:0]           mapped;

    always_comb begin
        i1_nxt = i1_q + W'(DS_IN);
        i2_nxt = i2_q + i1_nxt;
        c1     = i2_q - i2_dly_q;
    end

`ifdef DS_DECIMATOR_SATURATE_EN
    logic [W-1:0] raw;

    // raw never exceeds 2**MW in steady state, so the top bit alone flags overflow.
    always_comb begin
        raw    = c1 - c1_dly_q;
        mapped = raw[W-1] ? {MW{1'b1}} : raw[MW-1:0];
    end
`else
    always_comb begin
        mapped = MW'(c1 - c1_dly_q);
    end
`endif

    // Integrators, decimation counter and comb; DATA holds across SYNC_CLR.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i2_dly_q <= '0;
            c1_dly_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            map_q    <= '0;
            upd_q    <= 1'b0;
            data_q   <= '0;
        end else if (SYNC_CLR) begin
            i1_q     <= '0;
            i2_q     <= '0;
            i2_dly_q <= '0;
            c1_dly_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            if (DS_EN) begin
                i1_q  <= i1_nxt;
                i2_q  <= i2_nxt;
                cnt_q <= cnt_q + C_DEC_LOG2'(1);
            end
            tick_q <= DS_EN && (cnt_q == {C_DEC_LOG2{1'b1}});
            if (tick_q) begin
                i2_dly_q <= i2_q;
                c1_dly_q <= c1;
                map_q    <= mapped;
            end
            upd_q <= tick_q;
            if (upd_q) begin
                data_q <= C_OUT_BITS'(map_q) << SHIFT;
            end
        end
    end

    // Warm-up sequencer: the first two ticks after reset/clear never raise VALID.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= StWarm0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (SYNC_CLR) begin
            state_q <= StWarm0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= tick_q && (state_q == StRun);
            valid_q <= pend_q;
            if (tick_q) begin
                case (state_q)
                    StWarm0: state_q <= StWarm1;
                    StWarm1: state_q <= StRun;
                    StRun:   state_q <= StRun;
                    default: state_q <= StWarm0;
                endcase
            end
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;

    valid_one_cycle: assert property (@(posedge CLK) disable iff (!RSTB) VALID |=> !VALID);

endmodule

// File: doc/ds_decimator.md
# ds_decimator

Digital back end for the 1-bit delta-sigma modulator: accepts the comparator/flip-flop bitstream (`dsOut`) and reconstructs multi-bit samples.
- Second-order sinc (CIC, order 2) decimator, decimation ratio R = 2^C_DEC_LOG2.
- Produces one left-aligned unsigned C_OUT_BITS-wide sample per R accepted bits, qualified by a one-cycle VALID strobe.
- Sits between the modulator output register and downstream sample consumers.

## Interface
- C_DEC_LOG2, 6, log2 of decimation ratio R (R = 64); legal range 2..7.
- C_OUT_BITS, 16, output sample width; must satisfy C_OUT_BITS >= 2*C_DEC_LOG2.

- CLK  in  1  system clock; all state on the rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- DS_IN  in  1  modulator bitstream; 1 = +1, 0 = 0 (unipolar, GND..VDD).
- DS_EN  in  1  sample enable; DS_IN is accepted on a rising edge only when DS_EN = 1.
- SYNC_CLR  in  1  synchronous clear of the filter and warm-up state.
- DATA  out  C_OUT_BITS  decimated sample, unsigned, left-aligned.
- VALID  out  1  one-cycle strobe; DATA is new and stable while VALID = 1.

## Operation
- Internal width W = 2*C_DEC_LOG2 + 1. All integrator and comb arithmetic is unsigned modulo 2^W; integrator wrap-around is legal and expected.
- **Integrator stage**, on an accepted sample:
  - i1 <= i1 + DS_IN
  - i2 <= i2 + i1_next
- **Decimation counter** cnt (C_DEC_LOG2 bits):
  - Increments on every accepted sample and wraps R-1 -> 0.
  - Acceptance with cnt = R-1 sets the tick flag for one cycle.
- **Comb stage**, on a tick cycle, using pre-edge register values:
  - c1 = i2 - i2_d
  - raw = c1 - c1_d
  - Registers update: i2_d <= i2, c1_d <= c1.
  - raw lies in 0..R^2.
- **Output mapping:** DATA <= map(raw) << (C_OUT_BITS - 2*C_DEC_LOG2). map is selected by the configuration macro.
- **Warm-up:**
  - A 2-bit counter suppresses VALID for the first two ticks after reset or SYNC_CLR.
  - The first VALID comes at the third tick. DATA is still updated during warm-up.
- **States:** WARM0 -> WARM1 -> RUN, each advancing on a tick. RUN is absorbing. SYNC_CLR or RSTB returns to WARM0.
- **SYNC_CLR = 1:**
  - Clears i1, i2, i2_d, c1_d, cnt, tick and VALID; state -> WARM0.
  - DATA holds its last value.
  - SYNC_CLR overrides a simultaneous DS_EN; that sample is dropped.
- DS_EN = 1 is permitted on every cycle, including tick cycles. Acceptance and comb update occur on the same edge without loss.

## Timing
- **Reset values:** DATA = 0, VALID = 0, all internal registers 0, state WARM0. Reset takes effect asynchronously; VALID falls immediately.
- **Latency:** VALID is high during the cycle following the second rising edge after the edge that accepted sample R-1 of a frame.
- **VALID width:** exactly one CLK cycle. No backpressure; the consumer must capture while VALID = 1.
- **VALID period:** R x (DS_EN period) in steady state.
- DS_IN is ignored while DS_EN = 0.

## Configuration
- Macro: DS_DECIMATOR_SATURATE_EN.
- **Defined:** map(raw) = min(raw, 2^(2*C_DEC_LOG2) - 1). Full-scale all-ones input clamps to the maximum code.
- **Undefined:** map(raw) = raw[2*C_DEC_LOG2-1:0] (truncation). Full-scale raw = R^2 wraps to 0. The upstream modulator must keep density < 1.
- No other behaviour changes.

## Test plan
All scenarios use defaults (R = 64, C_OUT_BITS = 16, shift 4).
- **Constant 0:** RSTB release, DS_EN = 1 every cycle, DS_IN = 0 -> no VALID for ticks 1-2; first VALID 2 edges after sample 191 accepted; DATA = 0x0000; then VALID every 64 cycles.
- **Half density:** DS_IN alternating 1,0, DS_EN every cycle -> after warm-up, every VALID has DATA = 0x8000 (raw 2048). Pattern 1,0,0,0 -> DATA = 0x4000.
- **Full scale:** DS_IN = 1 constant -> with DS_DECIMATOR_SATURATE_EN, DATA = 0xFFF0; without it, DATA = 0x0000.
- **Sparse enable:** DS_EN every 4th cycle, DS_IN alternating on accepted samples -> VALID period 256 cycles; DATA = 0x8000; DS_IN toggles while DS_EN = 0 have no effect.
- **Synchronous clear:** SYNC_CLR pulse mid-frame coincident with DS_EN -> that sample dropped; no VALID for the next two ticks; third tick VALID with the correct steady value; DATA held until then.
- **Async reset:** RSTB asserted during a VALID cycle -> VALID and DATA go to 0 immediately. After release, warm-up restarts: first VALID 192 accepted samples later.
